// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared encodings for the R500 branch predictor
package branch_predictor_pkg;

    // 2-bit prediction encodings; MSB set means predict taken
    typedef enum logic [1:0] {
        PRED_SNT = 2'b00,
        PRED_WNT = 2'b01,
        PRED_WT  = 2'b10,
        PRED_ST  = 2'b11
    } pred_e;

    // BRU outcome codes reported back from EX
    typedef enum logic [1:0] {
        ST_MISS_NT = 2'd0,
        ST_MISS_T  = 2'd1,
        ST_HIT_NT  = 2'd2,
        ST_HIT_T   = 2'd3
    } status_e;

    // Predictor sequencing: table sweep after reset, then normal operation
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_state_e;

    // Actual branch direction implied by a BRU status code
    function automatic logic status_taken(input logic [1:0] status);
        return (status == ST_MISS_NT) || (status == ST_HIT_T);
    endfunction

    // Status codes that mean the fetch stream went the wrong way
    function automatic logic status_mispredict(input logic [1:0] status);
        return (status == ST_MISS_NT) || (status == ST_MISS_T);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating up/down counter step
module bp_sat_counter (
    input  logic [1:0] i_cnt,
    input  logic       i_inc,
    output logic [1:0] o_cnt
);

    // Step toward strongly-taken or strongly-not-taken, holding at the ends
    always_comb begin
        o_cnt = i_cnt;
        if (i_inc) begin
            if (i_cnt != 2'b11) o_cnt = i_cnt + 2'b01;
        end else begin
            if (i_cnt != 2'b00) o_cnt = i_cnt - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT/BTB branch predictor with EX redirect control
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] IF_pc,
    output logic [1:0]      IF_branch_prediction,
    output logic            IF_predict_taken,
    output logic [XLEN-1:0] IF_predicted_target,
    input  logic            EX_Branch,
    input  logic [XLEN-1:0] EX_pc,
    input  logic [XLEN-1:0] EX_branch_target,
    input  logic [1:0]      prediction_status,
    output logic            EX_flush,
    output logic [XLEN-1:0] EX_redirect_pc,
    output logic            init_done,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam int DEPTH    = 1 << IDX_BITS;

    // Prediction tables, one entry per index
    logic [1:0]          r_cnt [DEPTH];
    logic [DEPTH-1:0]    r_val;
    logic [TAG_BITS-1:0] r_tag [DEPTH];
    logic [XLEN-1:0]     r_tgt [DEPTH];

    bp_state_e           r_state;
    bp_state_e           w_state_nxt;
    logic [IDX_BITS-1:0] r_ptr;
    logic                w_sweep;
    logic                w_run;

    logic [CNT_W-1:0]    r_branch_count;
    logic [CNT_W-1:0]    r_mispredict_count;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_hit;
    logic [1:0]          w_lk_cnt;
    logic                w_ex_taken;
    logic                w_update;
    logic [1:0]          w_cnt_nxt;
    logic                w_unused_pc_lsbs;

    assign w_if_idx = IF_pc[IDX_BITS+1:2];
    assign w_if_tag = IF_pc[XLEN-1:IDX_BITS+2];
    assign w_ex_idx = EX_pc[IDX_BITS+1:2];
    assign w_ex_tag = EX_pc[XLEN-1:IDX_BITS+2];

    // Instructions are word aligned, so the low PC bits carry no information
    assign w_unused_pc_lsbs = ^{IF_pc[1:0], EX_pc[1:0]};

    assign w_ex_taken = status_taken(prediction_status);
    assign w_update   = w_run & EX_Branch;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: leave INIT once the last entry has been swept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (&r_ptr) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // FSM outputs: sweep enable in INIT, predictor live in RUN
    always_comb begin
        w_sweep = 1'b0;
        w_run   = 1'b0;
        case (r_state)
            S_INIT:  w_sweep = 1'b1;
            S_RUN:   w_run   = 1'b1;
            default: w_sweep = 1'b1;
        endcase
    end

    assign init_done = w_run;

    // Sweep pointer walks every entry once during INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_ptr <= '0;
        else if (w_sweep) r_ptr <= r_ptr + 1'b1;
    end

    // Counter update for the EX branch uses the stored counter, not a pipe copy
    bp_sat_counter u_sat (
        .i_cnt (r_cnt[w_ex_idx]),
        .i_inc (w_ex_taken),
        .o_cnt (w_cnt_nxt)
    );

    // Single write port: sweep in INIT, EX feedback in RUN
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_cnt[r_ptr] <= PRED_WNT;
            r_val[r_ptr] <= 1'b0;
        end else if (w_update) begin
            r_cnt[w_ex_idx] <= w_cnt_nxt;
            if (w_ex_taken) begin
                r_val[w_ex_idx] <= 1'b1;
                r_tag[w_ex_idx] <= w_ex_tag;
                r_tgt[w_ex_idx] <= EX_branch_target;
            end
        end
    end

    assign w_lk_cnt = r_cnt[w_if_idx];
    assign w_hit    = r_val[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);

    // IF lookup; a BTB miss still reports the counter's weak direction bit
    always_comb begin
        IF_branch_prediction = PRED_WNT;
        IF_predict_taken     = 1'b0;
        IF_predicted_target  = '0;
        if (w_run) begin
            IF_branch_prediction = w_hit ? w_lk_cnt : {1'b0, w_lk_cnt[0]};
            IF_predict_taken     = w_hit & w_lk_cnt[1];
            IF_predicted_target  = w_hit ? r_tgt[w_if_idx] : '0;
        end
    end

    // Mispredict redirect, valid in every state
    always_comb begin
        EX_flush       = 1'b0;
        EX_redirect_pc = '0;
        if (EX_Branch) begin
            case (prediction_status)
                ST_MISS_NT: begin
                    EX_flush       = 1'b1;
                    EX_redirect_pc = EX_branch_target;
                end
                ST_MISS_T: begin
                    EX_flush       = 1'b1;
                    EX_redirect_pc = EX_pc + XLEN'(4);
                end
                default: begin
                    EX_flush       = 1'b0;
                    EX_redirect_pc = '0;
                end
            endcase
        end
    end

    // Performance counters run in every state and wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (EX_Branch) begin
            r_branch_count <= r_branch_count + CNT_W'(1);
            if (status_mispredict(prediction_status))
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_br = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_tgt = '0;
    logic [1:0]  st = 2'd2;

    logic [1:0]  IF_branch_prediction;
    logic        IF_predict_taken;
    logic [31:0] IF_predicted_target;
    logic        EX_flush;
    logic [31:0] EX_redirect_pc;
    logic        init_done;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_cnt [64];
    bit          m_val [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          init_left;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    branch_predictor dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .IF_pc                (if_pc),
        .IF_branch_prediction (IF_branch_prediction),
        .IF_predict_taken     (IF_predict_taken),
        .IF_predicted_target  (IF_predicted_target),
        .EX_Branch            (ex_br),
        .EX_pc                (ex_pc),
        .EX_branch_target     (ex_tgt),
        .prediction_status    (st),
        .EX_flush             (EX_flush),
        .EX_redirect_pc       (EX_redirect_pc),
        .init_done            (init_done),
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        init_left = 64;
        m_bc = '0;
        m_mc = '0;
    endfunction

    function automatic logic [68:0] exp_vec();
        int          idx;
        bit          run;
        bit          hit;
        logic [1:0]  pred;
        logic [31:0] redir;
        idx  = int'(if_pc[7:2]);
        run  = (init_left == 0);
        hit  = run && m_val[idx] && (m_tag[idx] == if_pc[31:8]);
        if (!run)     pred = 2'd1;
        else if (hit) pred = 2'(m_cnt[idx]);
        else          pred = 2'(m_cnt[idx] % 2);
        if (!ex_br)        redir = 32'd0;
        else if (st == 0)  redir = ex_tgt;
        else if (st == 1)  redir = ex_pc + 32'd4;
        else               redir = 32'd0;
        return {pred, hit && (m_cnt[idx] >= 2), hit ? m_tgt[idx] : 32'd0,
                ex_br && (st < 2), redir, run};
    endfunction

    function automatic logic [68:0] obs_vec();
        return {IF_branch_prediction, IF_predict_taken, IF_predicted_target,
                EX_flush, EX_redirect_pc, init_done};
    endfunction

    // Apply inputs away from the active edge and let combinational outputs settle
    task automatic drive(input logic [31:0] pc, input logic br, input logic [31:0] epc,
                         input logic [31:0] etgt, input logic [1:0] s);
        @(negedge clk);
        if_pc = pc; ex_br = br; ex_pc = epc; ex_tgt = etgt; st = s;
        #1;
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (ex_br) begin
                m_bc = m_bc + 32'd1;
                if (st < 2) m_mc = m_mc + 32'd1;
            end
            if (init_left == 0) begin
                if (ex_br) begin
                    int i;
                    i = int'(ex_pc[7:2]);
                    if (st == 0 || st == 3) begin
                        if (m_cnt[i] < 3) m_cnt[i]++;
                        m_val[i] = 1'b1;
                        m_tag[i] = ex_pc[31:8];
                        m_tgt[i] = ex_tgt;
                    end else if (m_cnt[i] > 0) begin
                        m_cnt[i]--;
                    end
                end
            end else begin
                init_left--;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; if_pc = 32'h100; ex_br = 1'b0; st = 2'd2;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({branch_count, mispredict_count, init_done} !== {32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0b required 0/0/0",
                     branch_count, mispredict_count, init_done);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i <= 64; i++) begin
            drive(32'h40, 1'b0, 32'h0, 32'h0, 2'd2);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL init_sweep cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (init_done !== (i == 64) || IF_branch_prediction !== 2'b01) begin
                errors++;
                $display("FAIL init_done cycle %0d: got done=%0b pred=%b required done=%0b pred=01",
                         i, init_done, IF_branch_prediction, (i == 64));
            end
            tick();
        end
    endtask

    task automatic test_train_and_mispredict();
        drive(32'h100, 1'b1, 32'h100, 32'h80, 2'd0);
        checks++;
        if ({EX_flush, EX_redirect_pc} !== {1'b1, 32'h80} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL first_miss: got flush=%0b redirect=%h required 1/00000080", EX_flush, EX_redirect_pc);
        end
        tick();
        drive(32'h100, 1'b0, 32'h0, 32'h0, 2'd0);
        checks++;
        if ({IF_branch_prediction, IF_predict_taken, IF_predicted_target} !== {2'b10, 1'b1, 32'h80}
            || EX_flush !== 1'b0) begin
            errors++;
            $display("FAIL trained_lookup: got pred=%b taken=%0b target=%h flush=%0b required 10/1/00000080/0",
                     IF_branch_prediction, IF_predict_taken, IF_predicted_target, EX_flush);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h0, 1'b1, 32'h100, 32'h80, 2'd3);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL taken_ok %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(32'h100, 1'b0, 32'h0, 32'h0, 2'd3);
        checks++;
        if (IF_branch_prediction !== 2'b11) begin
            errors++;
            $display("FAIL saturate_up: got %b required 11", IF_branch_prediction);
        end
        tick();
        drive(32'h0, 1'b1, 32'h100, 32'h80, 2'd1);
        checks++;
        if ({EX_flush, EX_redirect_pc} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL taken_miss: got flush=%0b redirect=%h required 1/00000104", EX_flush, EX_redirect_pc);
        end
        tick();
        drive(32'h100, 1'b0, 32'h0, 32'h0, 2'd0);
        checks++;
        if (IF_branch_prediction !== 2'b10 || mispredict_count !== 32'd2 || branch_count !== 32'd5) begin
            errors++;
            $display("FAIL after_miss: got pred=%b mc=%0d bc=%0d required 10/2/5",
                     IF_branch_prediction, mispredict_count, branch_count);
        end
        tick();
    endtask

    task automatic test_aliasing();
        drive(32'h200, 1'b0, 32'h0, 32'h0, 2'd2);
        checks++;
        if ({IF_branch_prediction, IF_predict_taken, IF_predicted_target} !== {2'b00, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL alias_miss: got pred=%b taken=%0b target=%h required 00/0/00000000",
                     IF_branch_prediction, IF_predict_taken, IF_predicted_target);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(32'h100, 1'b1, 32'h100, 32'h80, 2'd3);
        checks++;
        if (IF_branch_prediction !== 2'b10 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL same_cycle_old: got pred=%b required 10", IF_branch_prediction);
        end
        tick();
        drive(32'h100, 1'b0, 32'h0, 32'h0, 2'd2);
        checks++;
        if (IF_branch_prediction !== 2'b11) begin
            errors++;
            $display("FAIL same_cycle_new: got pred=%b required 11", IF_branch_prediction);
        end
        tick();
    endtask

    task automatic test_boundaries();
        drive(32'h40, 1'b1, 32'hFFFF_FFFC, 32'h1234, 2'd1);
        checks++;
        if ({EX_flush, EX_redirect_pc} !== {1'b1, 32'h0} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pc_wrap: got flush=%0b redirect=%h required 1/00000000", EX_flush, EX_redirect_pc);
        end
        tick();
        drive(32'h40, 1'b0, 32'h100, 32'h80, 2'd0);
        checks++;
        if ({EX_flush, EX_redirect_pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL no_branch_gate: got flush=%0b redirect=%h required 0/00000000", EX_flush, EX_redirect_pc);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            drive(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2),
                  ($urandom_range(0, 3) != 0), a, $urandom & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_outputs %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if ({branch_count, mispredict_count} !== {m_bc, m_mc}) begin
                errors++;
                $display("FAIL random_counters %0d: got %0d/%0d required %0d/%0d",
                         i, branch_count, mispredict_count, m_bc, m_mc);
            end
            tick();
        end
    endtask

    // Drop reset asynchronously mid-cycle, then follow the full resweep
    task automatic test_async_reset(input string tag, input int pre_cycles);
        test_random(pre_cycles);
        drive(32'h100, 1'b1, 32'h100, 32'h80, 2'd0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({branch_count, mispredict_count, init_done, IF_branch_prediction} !== {32'd0, 32'd0, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL %s_reset: got bc=%0d mc=%0d done=%0b pred=%b required 0/0/0/01",
                     tag, branch_count, mispredict_count, init_done, IF_branch_prediction);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            drive(32'h100, (i % 5 == 0), 32'h100, 32'h80, 2'd0);
            checks++;
            if (obs_vec() !== exp_vec() || {branch_count, mispredict_count} !== {m_bc, m_mc}) begin
                errors++;
                $display("FAIL %s_resweep %0d: got %h bc=%0d required %h bc=%0d",
                         tag, i, obs_vec(), branch_count, exp_vec(), m_bc);
            end
            checks++;
            if (init_done !== (i == 64)) begin
                errors++;
                $display("FAIL %s_done %0d: got %0b required %0b", tag, i, init_done, (i == 64));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_train_and_mispredict();
        test_aliasing();
        test_same_cycle();
        test_boundaries();
        test_random(300);
        test_async_reset("mid_run", 20);
        test_random(100);
        drive(32'h0, 1'b0, 32'h0, 32'h0, 2'd2);
        tick();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        test_async_reset("mid_init", 20);
        test_random(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
